// File: rtl/msx_fdc_ctrl_multi.sv
// MSX multi-drive disk-cartridge glue: register window decode, FDC select, side/drive/motor and disk-change latches.
// Optional motor auto-off timer enabled by defining MSX_FDC_MOTOR_TIMEOUT_EN.
module msx_fdc_ctrl_multi #(
  parameter int          NUM_DRIVES  = 2,
  parameter logic [13:0] BASE_ADDR   = 14'h3FF8,
  parameter int          MOTOR_TICKS = 7159090
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [15:0]           addr,
  input  logic [7:0]            d_from_cpu,
  output logic [7:0]            d_to_cpu,
  input  logic                  sltsl_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  output logic                  fdc_cs,
  input  logic [7:0]            fdc_dout,
  input  logic                  fdc_drq,
  input  logic                  fdc_intrq,
  input  logic [NUM_DRIVES-1:0] img_mounted,
  input  logic [NUM_DRIVES-1:0] img_nz,
  output logic                  side,
  output logic [1:0]            drive_sel,
  output logic                  motor_on,
  output logic                  in_use,
  output logic                  fdd_ready
);

  localparam int ND = NUM_DRIVES;

  logic          sel;
  logic [2:0]    ofs;
  logic          wr_prev, rd_prev, edge_arm;
  logic          wr_edge, rd_edge;
  logic          reg_wr, ctrl_wr, chg_rd;
  logic [ND-1:0] present, changed, chg_snap;
  logic          chg_hold;
  logic          chg_sel, prs_sel;
  logic [7:0]    chg_byte;
  logic          unused_bits;

  assign sel    = ~sltsl_n && (addr[15:14] == 2'b01) && (addr[13:3] == BASE_ADDR[13:3]);
  assign ofs    = addr[2:0];
  assign fdc_cs = sel && (ofs[2] == 1'b0);

  // edge_arm suppresses a false edge from a strobe already low when reset releases
  assign wr_edge = edge_arm && wr_prev && ~wr_n;
  assign rd_edge = edge_arm && rd_prev && ~rd_n;

  assign reg_wr  = wr_edge && sel;
  assign ctrl_wr = reg_wr && (ofs == 3'd5);
  assign chg_rd  = rd_edge && sel && (ofs == 3'd6);

  assign unused_bits = ^{d_from_cpu[5:2], clk_en};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev  <= 1'b1;
      rd_prev  <= 1'b1;
      edge_arm <= 1'b0;
    end else begin
      wr_prev  <= wr_n;
      rd_prev  <= rd_n;
      edge_arm <= 1'b1;
    end
  end

`ifdef MSX_FDC_MOTOR_TIMEOUT_EN
  localparam logic [23:0] TICKS = 24'(MOTOR_TICKS);
  logic [23:0] timer;
  logic        tmr_load;

  assign tmr_load = (ctrl_wr && d_from_cpu[7]) || ((wr_edge || rd_edge) && fdc_cs);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      side      <= 1'b0;
      drive_sel <= 2'd0;
      motor_on  <= 1'b0;
      in_use    <= 1'b0;
`ifdef MSX_FDC_MOTOR_TIMEOUT_EN
      timer     <= 24'd0;
`endif
    end else begin
      if (reg_wr && (ofs == 3'd4))
        side <= d_from_cpu[0];
`ifdef MSX_FDC_MOTOR_TIMEOUT_EN
      // A reload takes priority over expiry, so an access at the last tick keeps the motor spinning
      if (ctrl_wr && !d_from_cpu[7]) begin
        timer <= 24'd0;
      end else if (tmr_load) begin
        timer <= TICKS;
      end else if (clk_en && motor_on && (timer != 24'd0)) begin
        timer <= timer - 24'd1;
        if (timer == 24'd1) begin
          motor_on <= 1'b0;
          in_use   <= 1'b0;
        end
      end
`endif
      if (ctrl_wr) begin
        drive_sel <= d_from_cpu[1:0];
        in_use    <= d_from_cpu[6];
        motor_on  <= d_from_cpu[7];
      end
    end
  end

  // Mount sets win over a read-clear landing on the same clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      present  <= '0;
      changed  <= '0;
      chg_snap <= '0;
      chg_hold <= 1'b0;
    end else begin
      present <= (present & ~img_mounted) | (img_nz & img_mounted);
      if (chg_rd)
        changed <= img_mounted;
      else
        changed <= changed | img_mounted;
      if (chg_rd) begin
        chg_snap <= changed;
        chg_hold <= 1'b1;
      end else if (rd_n) begin
        chg_hold <= 1'b0;
      end
    end
  end

  always_comb begin
    chg_sel = 1'b0;
    prs_sel = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (drive_sel == 2'(i)) begin
        chg_sel = changed[i];
        prs_sel = present[i];
      end
    end
  end

  assign fdd_ready = motor_on && prs_sel;

  always_comb begin
    chg_byte         = 8'hFF;
    chg_byte[ND-1:0] = chg_hold ? chg_snap : changed;
  end

  always_comb begin
    d_to_cpu = 8'hFF;
    if (sel && !rd_n) begin
      case (ofs)
        3'd4:    d_to_cpu = {7'h7F, ~side};
        3'd5:    d_to_cpu = {motor_on, in_use, chg_sel, 3'b111, drive_sel};
        3'd6:    d_to_cpu = chg_byte;
        3'd7:    d_to_cpu = {~fdc_drq, ~fdc_intrq, 6'h3F};
        default: d_to_cpu = fdc_dout;
      endcase
    end
  end

endmodule

// File: tb/tb_msx_fdc_ctrl_multi.sv
// Scoreboard bench for msx_fdc_ctrl_multi; timer checks run when MSX_FDC_MOTOR_TIMEOUT_EN is defined.
module tb_msx_fdc_ctrl_multi;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  d_from_cpu = 8'h00;
  logic [7:0]  d_to_cpu;
  logic        sltsl_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        fdc_cs;
  logic [7:0]  fdc_dout = 8'h00;
  logic        fdc_drq = 1'b0;
  logic        fdc_intrq = 1'b0;
  logic [1:0]  img_mounted = 2'b00;
  logic [1:0]  img_nz = 2'b00;
  logic        side;
  logic [1:0]  drive_sel;
  logic        motor_on;
  logic        in_use;
  logic        fdd_ready;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  msx_fdc_ctrl_multi #(
    .NUM_DRIVES (2),
    .BASE_ADDR  (14'h3FF8),
    .MOTOR_TICKS(100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .addr       (addr),
    .d_from_cpu (d_from_cpu),
    .d_to_cpu   (d_to_cpu),
    .sltsl_n    (sltsl_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .fdc_cs     (fdc_cs),
    .fdc_dout   (fdc_dout),
    .fdc_drq    (fdc_drq),
    .fdc_intrq  (fdc_intrq),
    .img_mounted(img_mounted),
    .img_nz     (img_nz),
    .side       (side),
    .drive_sel  (drive_sel),
    .motor_on   (motor_on),
    .in_use     (in_use),
    .fdd_ready  (fdd_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp,
                          input logic sl_n = 1'b0, input logic [1:0] mnt = 2'b00,
                          input logic [1:0] nz = 2'b00);
    logic [7:0] got;
    @(negedge clk);
    addr = a; sltsl_n = sl_n; rd_n = 1'b0; img_mounted = mnt; img_nz = nz;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    img_mounted = 2'b00;
    got = d_to_cpu;
    check($sformatf("rd_%h", a), {24'd0, got}, {24'd0, exp_q.pop_front()});
    @(negedge clk);
    rd_n = 1'b1;
    @(negedge clk);
    sltsl_n = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; d_from_cpu = d; sltsl_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    sltsl_n = 1'b1;
  endtask

  task automatic mount(input logic [1:0] m, input logic [1:0] nz);
    @(negedge clk);
    img_mounted = m; img_nz = nz;
    @(negedge clk);
    img_mounted = 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clk_en = 1'b1;
      @(negedge clk); clk_en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_side", {31'd0, side}, 32'd0);
    check("rst_dsel", {30'd0, drive_sel}, 32'd0);
    check("rst_motor", {31'd0, motor_on}, 32'd0);
    check("rst_inuse", {31'd0, in_use}, 32'd0);
    check("rst_ready", {31'd0, fdd_ready}, 32'd0);
    check("rst_cs", {31'd0, fdc_cs}, 32'd0);
    check("rst_dout", {24'd0, d_to_cpu}, 32'hFF);

    cpu_read(16'h7FFC, 8'hFF);
    cpu_read(16'h7FFD, 8'h1C);
    cpu_read(16'h7FFF, 8'hFF);
    cpu_read(16'h7FFE, 8'hFC);
    cpu_read(16'h7FFD, 8'hFF, 1'b1);
    cpu_read(16'hBFFD, 8'hFF);

    fdc_drq = 1'b1;
    cpu_read(16'h7FFF, 8'h7F);
    fdc_drq = 1'b0; fdc_intrq = 1'b1;
    cpu_read(16'h7FFF, 8'hBF);
    fdc_intrq = 1'b0;

    fdc_dout = 8'h5A;
    cpu_read(16'h7FF9, 8'h5A);
    @(negedge clk);
    addr = 16'h7FFA; sltsl_n = 1'b0;
    #1 check("cs_on", {31'd0, fdc_cs}, 32'd1);
    addr = 16'h7FFC;
    #1 check("cs_off_reg", {31'd0, fdc_cs}, 32'd0);
    sltsl_n = 1'b1;

    mount(2'b10, 2'b10);
    cpu_write(16'h7FFD, 8'h81);
    check("dsel1", {30'd0, drive_sel}, 32'd1);
    check("motor1", {31'd0, motor_on}, 32'd1);
    check("ready1", {31'd0, fdd_ready}, 32'd1);
    cpu_read(16'h7FFD, 8'hBD);
    cpu_read(16'h7FFE, 8'hFE);
    cpu_read(16'h7FFE, 8'hFC);

    cpu_read(16'h7FFE, 8'hFC, 1'b0, 2'b01, 2'b00);
    cpu_read(16'h7FFE, 8'hFD);
    cpu_read(16'h7FFE, 8'hFC);

    cpu_write(16'h7FFD, 8'h83);
    check("dsel3", {30'd0, drive_sel}, 32'd3);
    check("ready_oob", {31'd0, fdd_ready}, 32'd0);
    cpu_read(16'h7FFD, 8'h9F);

    cpu_write(16'h7FFC, 8'h01);
    check("side1", {31'd0, side}, 32'd1);
    cpu_read(16'h7FFC, 8'hFE);

    @(negedge clk);
    addr = 16'h7FFC; d_from_cpu = 8'h00; sltsl_n = 1'b0; wr_n = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      d_from_cpu = 8'(k & 1);
    end
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    sltsl_n = 1'b1;
    check("held_wr_once", {31'd0, side}, 32'd0);

    @(negedge clk);
    addr = 16'h7FFC; d_from_cpu = 8'h01; sltsl_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_wr", {31'd0, side}, 32'd0);
    check("rst_mid_motor", {31'd0, motor_on}, 32'd0);
    wr_n = 1'b1;
    @(negedge clk);
    sltsl_n = 1'b1;
    cpu_write(16'h7FFC, 8'h01);
    check("wr_after_rst", {31'd0, side}, 32'd1);

`ifdef MSX_FDC_MOTOR_TIMEOUT_EN
    cpu_write(16'h7FFD, 8'hC0);
    check("tmo_on", {31'd0, motor_on}, 32'd1);
    ticks(99);
    check("tmo_99", {31'd0, motor_on}, 32'd1);
    cpu_read(16'h7FF8, 8'h5A);
    ticks(99);
    check("tmo_reload_99", {31'd0, motor_on}, 32'd1);
    check("tmo_reload_inuse", {31'd0, in_use}, 32'd1);
    ticks(1);
    check("tmo_expire", {31'd0, motor_on}, 32'd0);
    check("tmo_expire_inuse", {31'd0, in_use}, 32'd0);
    cpu_write(16'h7FFD, 8'h80);
    ticks(5);
    cpu_write(16'h7FFD, 8'h00);
    check("tmo_manual_off", {31'd0, motor_on}, 32'd0);
    ticks(100);
    check("tmo_stays_off", {31'd0, motor_on}, 32'd0);
`endif

    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
